variable_length_unpacker: RTL and testbench
===========================================

Name: variable_length_unpacker

Overview:
- Parametrised bit-stream unpacker: accepts fixed WIDTH_IN-bit words and serves a WIDTH_OUT-bit look-ahead window from which the consumer removes 0..WIDTH_OUT bits per cycle.
- Sits between a word-oriented input FIFO and variable-length symbol decoders (Huffman/Golomb stages).
- Adds the following over the previous generation:
  - valid/ready input handshake
  - guarded pops, with underflow and overflow flags
  - selectable bit order
  - a valid-bit count on the output window

Parameters:
- WIDTH_IN, 8: bits per input word; 1..BUFFER_WIDTH.
- WIDTH_OUT, 8: output window width and the maximum bits per pop; 1..BUFFER_WIDTH.
- BUFFER_WIDTH, 32: storage in bits; must be >= WIDTH_IN + WIDTH_OUT.
- MSB_FIRST, 0: 0 means bit 0 of d is consumed first; 1 means bit WIDTH_IN-1 of d is consumed first.
- Derived localparams (via log2(x-1) from common.vh):
  - LB = log2(BUFFER_WIDTH-1)
  - LO = log2(WIDTH_OUT-1)

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- push, input, 1: input word valid.
- d, input, WIDTH_IN: input word.
- in_ready, output, 1: room for one word; high when size <= BUFFER_WIDTH-WIDTH_IN.
- pop, input, LO+1: number of bits to consume this cycle.
- q, output, WIDTH_OUT: look-ahead window; the next bit to consume is q[0] (MSB_FIRST=0) or q[WIDTH_OUT-1] (MSB_FIRST=1).
- q_bits, output, LO+1: valid bits in q, equal to min(size, WIDTH_OUT).
- size, output, LB+1: bits currently held.
- err, output, 2: sticky flags; [0] underflow, [1] overflow.

Behaviour:
- Reset: on rst at a clock edge, the following all clear to 0 the next cycle: buffer, size, err, q, q_bits. in_ready reads 1.
- Internal storage is LSB-first: buffer[0] is always the oldest bit. When MSB_FIRST=1, d is bit-reversed on entry and the low WIDTH_OUT bits are bit-reversed onto q.
- Pop acceptance:
  - A pop is accepted when pop <= size and pop <= WIDTH_OUT.
  - Accepted pop: buffer shifts right by pop, zero-filled; size decreases by pop.
  - pop = 0 is a legal no-op.
  - Rejected pop: no shift, and err[0] is set.
- Push acceptance:
  - A push is accepted only when in_ready is high.
  - in_ready is a function of the registered size only. There is no combinational path from pop to in_ready, and a same-cycle pop does not raise it.
  - Push with in_ready low: the word is dropped and err[1] is set.
- Simultaneous accepted pop and push:
  - The pop is applied first.
  - The word is OR-ed in at bit position (size - accepted pop).
  - Next size = size - accepted pop + WIDTH_IN.
- Zero-fill: bits at and above size are always 0, so q is zero above q_bits (before reversal).
- Latency: a word pushed in cycle N is visible on q, size and q_bits in cycle N+1. All outputs are registered state or combinational functions of registered state only.
- Width rules:
  - Arithmetic on size is done in LB+2 bits so it never wraps.
  - The shift amount is clamped to 0 when the pop is rejected.
  - The buffer is BUFFER_WIDTH bits; the shift-in width is BUFFER_WIDTH.
- Error flags: err bits clear only on rst. A rejected pop and a dropped push in the same cycle set both flags; any accepted half of that cycle still completes.
- Reset mid-stream: all buffered bits are discarded. push and pop in the reset cycle are ignored.

Decomposition:
- Shared include common.vh keeps the log2 constant function. A shared package/include adds named constants ERR_UNDERFLOW=0 and ERR_OVERFLOW=1 for err bit indices, reused by the downstream decoders.
- One natural sub-module: bit_reverse, parameter WIDTH, purely combinational.
  - Instantiated on d (WIDTH_IN) and on q (WIDTH_OUT) under a generate on MSB_FIRST.
- Core expected size: ~150-250 RTL lines.

Test Plan:
- Defaults, MSB_FIRST=0: after rst, push d=0xA5 → next cycle size=8, q=0xA5, q_bits=8, in_ready=1; then pop=3 → q=0x14, size=5.
- Push 0xFF, then in one cycle push 0x01 with pop=4 → size=12, q=0x1F (0x0F | 0x01<<4), q_bits=8, err=0.
- Fill to size=32 with four pushes → in_ready=0 once size>24. A further push is dropped, err[1]=1, size stays 32, and q is unchanged.
- size=5, pop=6 → pop rejected, err[0]=1, size=5, q unchanged. A subsequent pop=5 is accepted → size=0, q=0, q_bits=0.
- MSB_FIRST=1: push 0xA5 → q=0xA5 viewed MSB-first (q[7]=1 is the first bit). pop=1 → q=0x4A, size=7.
- Mid-stream rst with push=1, pop=2 asserted → next cycle size=0, q=0, err=0, in_ready=1; the pushed word is not stored.

Source files
------------

// File: rtl/variable_length_unpacker_pkg.sv
// Shared constants and helpers for the bit-stream unpacker and the
// downstream variable-length decoders.
package variable_length_unpacker_pkg;

  // Bit positions inside the sticky err vector.
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

  // Number of bits needed to represent x (0 for x = 0). Callers pass
  // (n-1) to get the index width of an n-entry range.
  function automatic int log2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((x >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/variable_length_unpacker_bit_reverse.sv
// Purely combinational bit-order reversal: y[i] = a[WIDTH-1-i].
module bit_reverse #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Mirror the vector end for end.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = a[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/variable_length_unpacker.sv
// Variable-length bit-stream unpacker. Fixed-width words are appended to
// an LSB-first bit buffer (buffer[0] is always the oldest bit); the
// consumer sees a WIDTH_OUT-bit look-ahead window and removes 0..WIDTH_OUT
// bits per cycle. Bad pops and dropped pushes raise sticky error flags.
module variable_length_unpacker
  import variable_length_unpacker_pkg::*;
#(
  parameter int WIDTH_IN     = 8,
  parameter int WIDTH_OUT    = 8,
  parameter int BUFFER_WIDTH = 32,
  parameter bit MSB_FIRST    = 1'b0,
  localparam int LB = log2(BUFFER_WIDTH - 1),
  localparam int LO = log2(WIDTH_OUT - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH_IN-1:0]  d,
  output logic                 in_ready,
  input  logic [LO:0]          pop,
  output logic [WIDTH_OUT-1:0] q,
  output logic [LO:0]          q_bits,
  output logic [LB:0]          size,
  output logic [1:0]           err
);

  // Size arithmetic runs one bit wider than size itself so that neither
  // the subtraction nor the push addition can wrap.
  localparam int SW  = LB + 2;
  localparam int SZW = LB + 1;
  localparam int QW  = LO + 1;

  localparam logic [SW-1:0] PUSH_LIMIT = SW'(BUFFER_WIDTH - WIDTH_IN);
  localparam logic [SW-1:0] POP_MAX    = SW'(WIDTH_OUT);
  localparam logic [SW-1:0] WORD_BITS  = SW'(WIDTH_IN);

  logic [BUFFER_WIDTH-1:0] buffer;
  logic [BUFFER_WIDTH-1:0] buffer_next;
  logic [WIDTH_IN-1:0]     d_lsb;
  logic [WIDTH_OUT-1:0]    q_lsb;
  logic [SW-1:0]           size_ext;
  logic [SW-1:0]           pop_ext;
  logic [SW-1:0]           shift_amt;
  logic [SW-1:0]           base;
  logic [SW-1:0]           size_next;
  logic [1:0]              err_set;
  logic                    pop_ok;
  logic                    push_ok;

  assign size_ext = SW'(size);
  assign pop_ext  = SW'(pop);

  // Room check looks at registered size only: a pop in the same cycle
  // never opens the gate, keeping pop off the in_ready timing path.
  assign in_ready = (size_ext <= PUSH_LIMIT);

  // Window exposes the oldest bits; everything at and above size is zero.
  assign q_lsb  = buffer[WIDTH_OUT-1:0];
  assign q_bits = (size_ext > POP_MAX) ? QW'(WIDTH_OUT) : QW'(size);

  // Bit-order adaptation on the way in and on the way out.
  if (MSB_FIRST) begin : g_msb_first
    bit_reverse #(.WIDTH(WIDTH_IN))  u_rev_d (.a(d),     .y(d_lsb));
    bit_reverse #(.WIDTH(WIDTH_OUT)) u_rev_q (.a(q_lsb), .y(q));
  end else begin : g_lsb_first
    assign d_lsb = d;
    assign q     = q_lsb;
  end

  // Next buffer/size: apply the accepted pop first, then OR the new word
  // in directly above the surviving bits.
  // NOTE: every always_comb output gets a default before any condition so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    pop_ok      = (pop_ext <= size_ext) && (pop_ext <= POP_MAX);
    push_ok     = push && in_ready;
    shift_amt   = pop_ok ? pop_ext : '0;
    base        = size_ext - shift_amt;
    buffer_next = buffer >> shift_amt;
    size_next   = base;
    if (push_ok) begin
      buffer_next = buffer_next | (BUFFER_WIDTH'(d_lsb) << base);
      size_next   = base + WORD_BITS;
    end
    err_set                = '0;
    err_set[ERR_UNDERFLOW] = !pop_ok;
    err_set[ERR_OVERFLOW]  = push && !in_ready;
  end

  // State update with synchronous reset; error flags are sticky until rst.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= '0;
      size   <= '0;
      err    <= '0;
    end else begin
      buffer <= buffer_next;
      size   <= SZW'(size_next);
      err    <= err | err_set;
    end
  end

endmodule

// File: tb/tb_variable_length_unpacker.sv
// Self-checking bench: two unpackers (LSB-first and MSB-first) share one
// stimulus stream and are compared every cycle against bit-queue models.
module tb_variable_length_unpacker;
  import variable_length_unpacker_pkg::*;

  localparam int WIN  = 8;
  localparam int WOUT = 8;
  localparam int BW   = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] d;
  logic [3:0] pop;

  logic       in_ready0, in_ready1;
  logic [7:0] q0, q1;
  logic [3:0] q_bits0, q_bits1;
  logic [5:0] size0, size1;
  logic [1:0] err0, err1;

  variable_length_unpacker #(
    .WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .MSB_FIRST(1'b0)
  ) u_dut_lsb (
    .clk(clk), .rst(rst), .push(push), .d(d), .in_ready(in_ready0),
    .pop(pop), .q(q0), .q_bits(q_bits0), .size(size0), .err(err0)
  );

  variable_length_unpacker #(
    .WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .MSB_FIRST(1'b1)
  ) u_dut_msb (
    .clk(clk), .rst(rst), .push(push), .d(d), .in_ready(in_ready1),
    .pop(pop), .q(q1), .q_bits(q_bits1), .size(size1), .err(err1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the bit stream in consumption order.
  bit   stream_lsb[$];
  bit   stream_msb[$];
  logic [1:0] err_m = 2'b00;
  int   m_size;
  bit   m_ready;

  always @(posedge clk) begin
    if (rst) begin
      stream_lsb.delete();
      stream_msb.delete();
      err_m = 2'b00;
    end else begin
      m_size  = stream_lsb.size();
      m_ready = (m_size <= BW - WIN);
      if (int'(pop) <= m_size && int'(pop) <= WOUT) begin
        for (int i = 0; i < int'(pop); i++) begin
          void'(stream_lsb.pop_front());
          void'(stream_msb.pop_front());
        end
      end else begin
        err_m[ERR_UNDERFLOW] = 1'b1;
      end
      if (push) begin
        if (m_ready) begin
          for (int i = 0; i < WIN; i++) begin
            stream_lsb.push_back(d[i]);
            stream_msb.push_back(d[WIN-1-i]);
          end
        end else begin
          err_m[ERR_OVERFLOW] = 1'b1;
        end
      end
    end
  end

  // Window expected from the model: first bit at q[0] or q[WOUT-1].
  function automatic logic [7:0] exp_q(input bit msb);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < WOUT && i < stream_lsb.size(); i++) begin
      if (msb) r[WOUT-1-i] = stream_msb[i];
      else     r[i]        = stream_lsb[i];
    end
    return r;
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (checking) begin
      int sz;
      sz = stream_lsb.size();
      check("lsb.size",     32'(size0),     32'(sz));
      check("lsb.q",        32'(q0),        32'(exp_q(1'b0)));
      check("lsb.q_bits",   32'(q_bits0),   32'((sz < WOUT) ? sz : WOUT));
      check("lsb.in_ready", 32'(in_ready0), 32'(sz <= BW - WIN));
      check("lsb.err",      32'(err0),      32'(err_m));
      check("msb.size",     32'(size1),     32'(sz));
      check("msb.q",        32'(q1),        32'(exp_q(1'b1)));
      check("msb.q_bits",   32'(q_bits1),   32'((sz < WOUT) ? sz : WOUT));
      check("msb.in_ready", 32'(in_ready1), 32'(sz <= BW - WIN));
      check("msb.err",      32'(err1),      32'(err_m));
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic step(input bit r, input bit p, input logic [7:0] dd, input logic [3:0] pp);
    rst  = r;
    push = p;
    d    = dd;
    pop  = pp;
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    d    = '0;
    pop  = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 4'd0);
    checking = 1'b1;
    check("rst.size",     32'(size0),     32'd0);
    check("rst.q",        32'(q0),        32'h0);
    check("rst.q_bits",   32'(q_bits0),   32'd0);
    check("rst.err",      32'(err0),      32'd0);
    check("rst.in_ready", 32'(in_ready0), 32'd1);

    // Single push then partial pop, rejected pop, exact drain.
    step(1'b0, 1'b1, 8'hA5, 4'd0);
    check("push.size",     32'(size0),     32'd8);
    check("push.q",        32'(q0),        32'hA5);
    check("push.q_bits",   32'(q_bits0),   32'd8);
    check("push.in_ready", 32'(in_ready0), 32'd1);
    check("push.q_msb",    32'(q1),        32'hA5);
    step(1'b0, 1'b0, 8'h00, 4'd3);
    check("pop3.q",    32'(q0),    32'h14);
    check("pop3.size", 32'(size0), 32'd5);
    step(1'b0, 1'b0, 8'h00, 4'd6);
    check("rej.err",  32'(err0),  32'b01);
    check("rej.size", 32'(size0), 32'd5);
    check("rej.q",    32'(q0),    32'h14);
    step(1'b0, 1'b0, 8'h00, 4'd5);
    check("drain.size",   32'(size0),   32'd0);
    check("drain.q",      32'(q0),      32'h0);
    check("drain.q_bits", 32'(q_bits0), 32'd0);

    // MSB-first single-bit pop.
    step(1'b1, 1'b0, 8'h00, 4'd0);
    step(1'b0, 1'b1, 8'hA5, 4'd0);
    step(1'b0, 1'b0, 8'h00, 4'd1);
    check("msb.pop1.q",    32'(q1),    32'h4A);
    check("msb.pop1.size", 32'(size1), 32'd7);

    // Simultaneous push and pop.
    step(1'b1, 1'b0, 8'h00, 4'd0);
    step(1'b0, 1'b1, 8'hFF, 4'd0);
    step(1'b0, 1'b1, 8'h01, 4'd4);
    check("pp.size",   32'(size0),   32'd12);
    check("pp.q",      32'(q0),      32'h1F);
    check("pp.q_bits", 32'(q_bits0), 32'd8);
    check("pp.err",    32'(err0),    32'd0);

    // Fill to capacity, then overflow.
    step(1'b1, 1'b0, 8'h00, 4'd0);
    step(1'b0, 1'b1, 8'h11, 4'd0);
    step(1'b0, 1'b1, 8'h22, 4'd0);
    step(1'b0, 1'b1, 8'h33, 4'd0);
    check("fill24.in_ready", 32'(in_ready0), 32'd1);
    step(1'b0, 1'b1, 8'h44, 4'd0);
    check("fill32.size",     32'(size0),     32'd32);
    check("fill32.in_ready", 32'(in_ready0), 32'd0);
    step(1'b0, 1'b1, 8'h55, 4'd0);
    check("ovf.err",  32'(err0),  32'b10);
    check("ovf.size", 32'(size0), 32'd32);
    check("ovf.q",    32'(q0),    32'h11);

    // Reset mid-stream with push and pop asserted.
    step(1'b1, 1'b1, 8'h77, 4'd2);
    check("mrst.size",     32'(size0),     32'd0);
    check("mrst.q",        32'(q0),        32'h0);
    check("mrst.err",      32'(err0),      32'd0);
    check("mrst.in_ready", 32'(in_ready0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 4'd0);
    check("mrst.nostore", 32'(size0), 32'd0);

    // Randomized traffic, with rare resets and occasional oversize pops.
    for (int n = 0; n < 3000; n++) begin
      bit         r, p;
      logic [3:0] pp;
      r  = ($urandom_range(0, 299) == 0);
      p  = ($urandom_range(0, 2) != 0);
      pp = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(9, 15))
                                        : 4'($urandom_range(0, 8));
      step(r, p, 8'($urandom), pp);
    end

    step(1'b0, 1'b0, 8'h00, 4'd0);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
